uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_pkg.sv | 20 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 116 +++++++++++
 tb/tb_uart_tx_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// ============================================================================
// Module : uart_tx_fifo_pkg
// Brief  : Shared UART byte width and drain-FSM state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_fifo_pkg;

    localparam int c_byte_w = 8;
    localparam int c_st_w   = 2;

    localparam logic [c_st_w-1:0] c_st_idle      = 2'd0;
    localparam logic [c_st_w-1:0] c_st_launch    = 2'd1;
    localparam logic [c_st_w-1:0] c_st_wait_busy = 2'd2;
    localparam logic [c_st_w-1:0] c_st_wait_done = 2'd3;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Register-array byte FIFO with wrap-bit pointers and fill status.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int   DEPTH  = 16,
    localparam int  ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic [c_byte_w-1:0] i_wr_data,
    input  logic                i_pop,
    output logic [c_byte_w-1:0] o_rd_data,
    output logic [ADDR_W:0]     o_count,
    output logic                o_full,
    output logic                o_empty
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [c_byte_w-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (i_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left unreset; occupancy lives in the pointers.
    always_ff @(posedge clk) begin
        if (i_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_wr_data;
    end

    assign o_rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign o_count   = wr_ptr_q - rd_ptr_q;
    assign o_full    = (o_count == c_depth);
    assign o_empty   = (o_count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module : uart_tx_fifo
// Brief  : Buffers received bytes and replays them to an idle UART transmitter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int   DEPTH        = 16,
    parameter int   BUSY_TIMEOUT = 4,
    localparam int  ADDR_W       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_done,
    input  logic [c_byte_w-1:0] rx_data,
    input  logic                tx_busy,
    output logic                tx_flag,
    output logic [c_byte_w-1:0] tx_data,
    output logic [ADDR_W:0]     fifo_count,
    output logic                fifo_full,
    output logic                fifo_empty,
    output logic                overflow,
    input  logic                clr_ovf
);

    localparam int              c_cnt_w   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(BUSY_TIMEOUT - 1);

    logic [c_st_w-1:0]   state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic [c_byte_w-1:0] tx_data_q, tx_data_d;
    logic                ovf_q, ovf_d;

    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic [c_byte_w-1:0] w_rd_data;

    // Full is taken from registered state, so a same-cycle pop never rescues a push.
    assign w_push = rx_done && !fifo_full;
    assign w_drop = rx_done &&  fifo_full;

    sync_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_wr_data  (rx_data),
        .i_pop      (w_pop),
        .o_rd_data  (w_rd_data),
        .o_count    (fifo_count),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_pop   = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (!fifo_empty && !tx_busy) begin
                    w_pop   = 1'b1;
                    state_d = c_st_launch;
                end
            end
            c_st_launch: begin
                cnt_d   = '0;
                state_d = c_st_wait_busy;
            end
            c_st_wait_busy: begin
                // A transmitter that never acknowledges is treated as having sent the byte.
                if (tx_busy)                state_d = c_st_wait_done;
                else if (cnt_q == c_to_last) state_d = c_st_idle;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            c_st_wait_done: begin
                if (!tx_busy) state_d = c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_comb begin
        tx_data_d = w_pop ? w_rd_data : tx_data_q;
        ovf_d     = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (w_drop)  ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= c_st_idle;
            cnt_q     <= '0;
            tx_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

    // Decoded from the state flop so reset drops the strobe without a clock edge.
    assign tx_flag  = (state_q == c_st_launch);
    assign tx_data  = tx_data_q;
    assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module : tb_uart_tx_fifo
// Brief  : Directed self-checking bench for uart_tx_fifo.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_flag;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
    logic       clr_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Transmitter model: busy for busy_len cycles after each tx_flag, or forced by hold.
    int   busy_len = 20;
    int   busy_cnt = 0;
    logic hold     = 1'b0;

    int         cyc = 0;
    logic [7:0] log_data [0:63];
    int         log_cyc  [0:63];
    int         log_n    = 0;

    uart_tx_fifo #(
        .DEPTH        (16),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .tx_busy    (tx_busy),
        .tx_flag    (tx_flag),
        .tx_data    (tx_data),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_flag && busy_len > 0) busy_cnt = busy_len;
        else if (busy_cnt > 0)       busy_cnt = busy_cnt - 1;
    end

    assign tx_busy = hold || (busy_cnt > 0);

    always @(negedge clk) begin
        if (rst_n && tx_flag && log_n < 64) begin
            log_data[log_n] = tx_data;
            log_cyc[log_n]  = cyc;
            log_n           = log_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    int base;

    initial begin
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        clr_ovf = 1'b0;
        wait_cycles(3);
        check("rst_flag",  32'(tx_flag),    32'd0);
        check("rst_data",  32'(tx_data),    32'h00);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full",  32'(fifo_full),  32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);
        rst_n = 1'b1;
        wait_cycles(3);

        // Single byte: count=1 next cycle, strobe the cycle after
        busy_len = 20;
        push(8'hA5);
        check("single_cnt1",  32'(fifo_count), 32'd1);
        check("single_noflg", 32'(tx_flag),    32'd0);
        tick();
        check("single_flag",  32'(tx_flag),    32'd1);
        check("single_data",  32'(tx_data),    32'hA5);
        check("single_cnt0",  32'(fifo_count), 32'd0);
        tick();
        check("single_pulse", 32'(tx_flag),    32'd0);
        wait_cycles(30);

        // Burst ordering with 20-cycle busy periods
        base = log_n;
        for (int i = 1; i <= 5; i++) push(8'(i));
        wait_cycles(130);
        check("burst_n", 32'(log_n - base), 32'd5);
        for (int i = 0; i < 5; i++) check("burst_data", 32'(log_data[base+i]), 32'(i + 1));
        for (int i = 1; i < 5; i++)
            check("burst_gap", 32'(log_cyc[base+i] - log_cyc[base+i-1] >= 22), 32'd1);

        // Full / overflow with the transmitter held busy
        busy_len = 3;
        hold     = 1'b1;
        base     = log_n;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        check("full_flag",  32'(fifo_full),  32'd1);
        check("full_count", 32'(fifo_count), 32'd16);
        check("full_noovf", 32'(overflow),   32'd0);
        push(8'h20);
        check("ovf_set",    32'(overflow),   32'd1);
        check("ovf_count",  32'(fifo_count), 32'd16);
        clr_ovf = 1'b1;
        push(8'h21);
        clr_ovf = 1'b0;
        check("ovf_drop_wins", 32'(overflow), 32'd1);
        hold = 1'b0;
        wait_cycles(100);
        check("full_n", 32'(log_n - base), 32'd16);
        for (int i = 0; i < 16; i++) check("full_data", 32'(log_data[base+i]), 32'h10 + 32'(i));
        check("drain_empty", 32'(fifo_empty), 32'd1);
        check("data_hold",   32'(tx_data),    32'h1F);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Simultaneous push and pop
        hold = 1'b1;
        base = log_n;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        check("sim_cnt_pre", 32'(fifo_count), 32'd3);
        hold = 1'b0;
        push(8'hA4);
        check("sim_cnt",  32'(fifo_count), 32'd3);
        check("sim_flag", 32'(tx_flag),    32'd1);
        check("sim_data", 32'(tx_data),    32'hA1);
        wait_cycles(40);
        check("sim_n", 32'(log_n - base), 32'd4);
        for (int i = 0; i < 4; i++) check("sim_order", 32'(log_data[base+i]), 32'hA1 + 32'(i));

        // Busy timeout: transmitter never acknowledges
        busy_len = 0;
        base     = log_n;
        push(8'hB1);
        push(8'hB2);
        wait_cycles(20);
        check("to_n",    32'(log_n - base), 32'd2);
        check("to_gap",  32'(log_cyc[base+1] - log_cyc[base]), 32'd6);
        check("to_data", 32'(log_data[base+1]), 32'hB2);

        // Asynchronous reset while waiting on a busy transmitter
        busy_len = 20;
        base     = log_n;
        for (int i = 0; i < 7; i++) push(8'hC0 + 8'(i));
        check("mid_cnt", 32'(fifo_count), 32'd6);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_flag",  32'(tx_flag),    32'd0);
        check("arst_data",  32'(tx_data),    32'h00);
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_empty", 32'(fifo_empty), 32'd1);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(30);
        check("arst_noflag", 32'(log_n - base), 32'd1);
        check("arst_empty2", 32'(fifo_empty),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
